truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the clock cycles each input pattern is held before sampling; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, sweep request, sampled in IDLE only.
REQ-005 The block SHALL have port f_in, input, 1, combinational result of the 4-input function under test.
REQ-006 The block SHALL have ports A, B, C, D, output, 1 each, the driven pattern; minterm index m = {A,B,C,D}, A is MSB.
REQ-007 The block SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse at sweep end.
REQ-009 The block SHALL have port table_out, output, 16, captured truth table; bit m = f_in under minterm m.
REQ-010 The block SHALL have port ones_count, output, 5, number of set bits in table_out (0..16).

Function
REQ-011 The FSM SHALL have states IDLE, DRIVE, SAMPLE, FINISH.
REQ-012 IDLE with start=1 SHALL go to DRIVE next cycle, clearing table_out, ones_count, index and settle counter to 0.
REQ-013 DRIVE SHALL hold {A,B,C,D}=index for SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-014 SAMPLE SHALL write f_in into table_out[index], add f_in to ones_count, and stay exactly one cycle.
REQ-015 From SAMPLE, index<15 SHALL go to DRIVE with index+1; index=15 SHALL go to FINISH with no wrap to 0 being sampled.
REQ-016 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 busy SHALL be high in DRIVE and SAMPLE, low in IDLE and FINISH.
REQ-018 With start sampled at edge k, done SHALL be high in cycle k+1+16*(SETTLE_CYCLES+1).
REQ-019 start during DRIVE, SAMPLE or FINISH SHALL be ignored; start held high SHALL restart one cycle after FINISH.
REQ-020 table_out and ones_count SHALL hold their final values in IDLE until the next accepted start.
REQ-021 In IDLE and FINISH, {A,B,C,D} SHALL be 4'b0000.
REQ-022 ones_count SHALL never exceed 16; 5-bit width SHALL be sufficient with no saturation logic.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE; A,B,C,D, busy, done = 0; table_out = 16'h0000; ones_count = 0.
REQ-024 rst_n asserted mid-sweep SHALL abort the sweep with no done pulse; partial results SHALL be discarded.
REQ-025 After rst_n deasserts, the block SHALL need a fresh start to sweep.

Configuration
REQ-026 Macro SWEEP_COMPARE_EN defined SHALL add input exp_table (16), output mismatch (1) and output mismatch_count (5).
REQ-027 With the macro, each SAMPLE SHALL increment mismatch_count when f_in != exp_table[index].
REQ-028 With the macro, mismatch SHALL be high in FINISH when mismatch_count != 0, and held until the next start.
REQ-029 Without the macro, these ports and counters SHALL not exist and the remaining behaviour SHALL be unchanged.

Structure
REQ-030 Package sweeper_pkg SHALL hold the state enum, NUM_MINTERMS=16 and INDEX_W=4.
REQ-031 One sub-module, settle_timer (load, tick, expired), SHALL implement the DRIVE hold count.

Verification
REQ-032 f_in = BD+CD+A'C'D'+BCD' of pins, SETTLE_CYCLES=1, start pulse -> table_out=16'hE8F9, ones_count=10, done 33 cycles after start edge.
REQ-033 f_in tied 0 then tied 1 -> table_out=16'h0000/ones_count=0, then 16'hFFFF/ones_count=16.
REQ-034 rst_n low at cycle 10 of a sweep -> all outputs 0 at once, no done; next start gives full correct sweep.
REQ-035 start pulsed at cycles 5 and 20 of a sweep -> ignored; exactly one done; SETTLE_CYCLES=3 -> done at k+65.
REQ-036 SWEEP_COMPARE_EN, exp_table=16'hE8F9, f_in with minterm 7 forced 0 -> mismatch=1, mismatch_count=1.

Source files
------------

// File: rtl/sweeper_pkg.sv
// Shared constants and FSM state encoding for the truth-table sweeper.
package sweeper_pkg;

  localparam int unsigned NUM_MINTERMS = 16;
  localparam int unsigned INDEX_W      = 4;
  localparam int unsigned COUNT_W      = 5;
  localparam int unsigned SETTLE_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// Counts the cycles a pattern has been held; expired flags the last hold cycle.
module settle_timer
  import sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (tick) begin
      count <= count + SETTLE_W'(1);
    end
  end

  assign expired = (count == SETTLE_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks minterms 0..15 on {A,B,C,D}, captures f_in per minterm into table_out.
// Optional SWEEP_COMPARE_EN adds exp_table comparison with mismatch flag/count.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               f_in,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               D,
  output logic               busy,
  output logic               done,
  output logic [15:0]        table_out,
  output logic [COUNT_W-1:0] ones_count
`ifdef SWEEP_COMPARE_EN
  ,
  input  logic [15:0]        exp_table,
  output logic               mismatch,
  output logic [COUNT_W-1:0] mismatch_count
`endif
);

  state_e              state, state_nxt;
  logic [INDEX_W-1:0]  index, index_nxt;
  logic                load, tick, expired;
  logic                busy_nxt;
  logic                accept;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .tick    (tick),
    .expired (expired)
  );

  // Next-state and timer control
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    load      = 1'b0;
    tick      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRIVE;
          index_nxt = '0;
          load      = 1'b1;
        end
      end
      DRIVE: begin
        if (expired) state_nxt = SAMPLE;
        else         tick      = 1'b1;
      end
      SAMPLE: begin
        if (index == INDEX_W'(NUM_MINTERMS - 1)) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = DRIVE;
          index_nxt = index + INDEX_W'(1);
          load      = 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt == DRIVE) || (state_nxt == SAMPLE);
  assign accept   = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
    end
  end

  // Registered pattern, status and capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {A, B, C, D} <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      ones_count   <= '0;
    end else begin
      {A, B, C, D} <= busy_nxt ? index_nxt : INDEX_W'(0);
      busy         <= busy_nxt;
      done         <= (state_nxt == FINISH);
      if (accept) begin
        table_out  <= '0;
        ones_count <= '0;
      end else if (state == SAMPLE) begin
        table_out[index] <= f_in;
        ones_count       <= ones_count + COUNT_W'(f_in);
      end
    end
  end

`ifdef SWEEP_COMPARE_EN
  logic               cmp_hit;
  logic [COUNT_W-1:0] mismatch_count_nxt;

  assign cmp_hit            = (f_in != exp_table[index]);
  assign mismatch_count_nxt = mismatch_count + COUNT_W'(cmp_hit);

  // Flag is evaluated with the final sample's contribution included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch       <= 1'b0;
      mismatch_count <= '0;
    end else if (accept) begin
      mismatch       <= 1'b0;
      mismatch_count <= '0;
    end else if (state == SAMPLE) begin
      mismatch_count <= mismatch_count_nxt;
      if (state_nxt == FINISH) mismatch <= (mismatch_count_nxt != '0);
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (SETTLE_CYCLES 1 and 3) against a cycle-count model.
module tb_truth_table_sweeper;

  typedef struct packed {
    logic [15:0] tbl;
    logic [4:0]  ones;
  } exp_t;

  localparam logic [15:0] EXP_REF = 16'hE8F9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int          mode = 0;
  logic [15:0] rand_tt = 16'h0000;

  logic a0, b0, c0, d0, busy0, done0, a1, b1, c1, d1, busy1, done1;
  logic [15:0] tbl0, tbl1;
  logic [4:0]  ones0, ones1;
  logic        f0, f1;
`ifdef SWEEP_COMPARE_EN
  logic        mm0, mm1;
  logic [4:0]  mmc0, mmc1;
`endif

  logic [3:0]  pat    [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic [15:0] tbl_w  [2];
  logic [4:0]  ones_w [2];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   act [2];
  int   k0 [2];
  logic [15:0] last_tbl [2];
  logic [4:0]  last_ones [2];
  exp_t sb0 [$];
  exp_t sb1 [$];
  exp_t e_push, e_pop;

  always #5 clk = ~clk;

  function automatic logic fn(input int md, input logic [3:0] m, input logic [15:0] tt);
    logic a, b, c, d, base;
    {a, b, c, d} = m;
    base = (b & d) | (c & d) | (~a & ~c & ~d) | (b & c & ~d);
    case (md)
      0:       return base;
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return tt[m];
      default: return (m == 4'd7) ? 1'b0 : base;
    endcase
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] model_table();
    logic [15:0] t;
    for (int m = 0; m < 16; m++) t[m] = fn(mode, 4'(m), rand_tt);
    return t;
  endfunction

  assign f0 = fn(mode, {a0, b0, c0, d0}, rand_tt);
  assign f1 = fn(mode, {a1, b1, c1, d1}, rand_tt);
  assign pat[0] = {a0, b0, c0, d0};
  assign pat[1] = {a1, b1, c1, d1};
  assign busy_w[0] = busy0;
  assign busy_w[1] = busy1;
  assign done_w[0] = done0;
  assign done_w[1] = done1;
  assign tbl_w[0] = tbl0;
  assign tbl_w[1] = tbl1;
  assign ones_w[0] = ones0;
  assign ones_w[1] = ones1;

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f0),
    .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
    .table_out(tbl0), .ones_count(ones0)
`ifdef SWEEP_COMPARE_EN
    , .exp_table(EXP_REF), .mismatch(mm0), .mismatch_count(mmc0)
`endif
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f1),
    .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
    .table_out(tbl1), .ones_count(ones1)
`ifdef SWEEP_COMPARE_EN
    , .exp_table(EXP_REF), .mismatch(mm1), .mismatch_count(mmc1)
`endif
  );

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @cyc %0d: got %0h expected %0h", name, i, cyc, got, exp);
    end
  endtask

  // Reference: a sweep accepted at edge k occupies 16*(S+1) cycles, then FINISH, then IDLE
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0;
        last_tbl[i] = '0;
        last_ones[i] = '0;
        if (i == 0) sb0.delete(); else sb1.delete();
      end else if (!act[i] && start) begin
        act[i] = 1'b1;
        k0[i] = cyc;
        e_push.tbl = model_table();
        e_push.ones = 5'($countones(e_push.tbl));
        last_tbl[i] = e_push.tbl;
        last_ones[i] = e_push.ones;
        if (i == 0) sb0.push_back(e_push); else sb1.push_back(e_push);
      end else if (act[i] && cyc == k0[i] + 16 * (settle_of(i) + 1) + 1) begin
        act[i] = 1'b0;
      end
    end
  end

  // Monitor: per-cycle status/pattern checks; pops scoreboard on each done
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        automatic int  per = settle_of(i) + 1;
        automatic bit  exp_busy = act[i] && (cyc < k0[i] + 16 * per);
        automatic bit  exp_done = act[i] && (cyc == k0[i] + 16 * per);
        automatic int  exp_pat = exp_busy ? (cyc - k0[i]) / per : 0;
        automatic int  sz = (i == 0) ? sb0.size() : sb1.size();
        chk("busy", i, 32'(busy_w[i]), 32'(exp_busy));
        chk("done", i, 32'(done_w[i]), 32'(exp_done));
        chk("pattern", i, 32'(pat[i]), 32'(exp_pat));
        if (done_w[i]) begin
          chk("sb_nonempty", i, 32'(sz != 0), 32'd1);
          if (sz != 0) begin
            if (i == 0) e_pop = sb0.pop_front(); else e_pop = sb1.pop_front();
            chk("table_out", i, 32'(tbl_w[i]), 32'(e_pop.tbl));
            chk("ones_count", i, 32'(ones_w[i]), 32'(e_pop.ones));
`ifdef SWEEP_COMPARE_EN
            begin
              automatic int nmm = $countones(e_pop.tbl ^ EXP_REF);
              chk("mismatch_count", i, 32'((i == 0) ? mmc0 : mmc1), 32'(nmm));
              chk("mismatch", i, 32'((i == 0) ? mm0 : mm1), 32'(nmm != 0));
            end
`endif
          end
        end
      end
    end
  end

  task automatic check_zero();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
      chk("rst_done", i, 32'(done_w[i]), 32'd0);
      chk("rst_pattern", i, 32'(pat[i]), 32'd0);
      chk("rst_table", i, 32'(tbl_w[i]), 32'd0);
      chk("rst_ones", i, 32'(ones_w[i]), 32'd0);
    end
`ifdef SWEEP_COMPARE_EN
    chk("rst_mismatch", 0, 32'({mm0, mmc0}), 32'd0);
    chk("rst_mismatch", 1, 32'({mm1, mmc1}), 32'd0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #2 start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
  endtask

  // Bounded wait for both sweeps, then confirm results hold in IDLE
  task automatic wait_idle();
    bit idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      idle = !act[0] && !act[1];
    end
    chk("idle_wait", 0, 32'(idle), 32'd1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("hold_table", i, 32'(tbl_w[i]), 32'(last_tbl[i]));
      chk("hold_ones", i, 32'(ones_w[i]), 32'(last_ones[i]));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 check_zero();
    #1 rst_n = 1'b1;

    // Known function: fixed table and popcount
    mode = 0;
    pulse_start();
    wait_idle();
    chk("ref_table", 0, 32'(tbl0), 32'(EXP_REF));
    chk("ref_ones", 0, 32'(ones0), 32'd10);

    // Extra start pulses mid-sweep must be ignored
    pulse_start();
    repeat (3) @(negedge clk);
    #2 start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
    repeat (14) @(negedge clk);
    #2 start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
    wait_idle();

    // Constant functions
    mode = 1;
    pulse_start();
    wait_idle();
    mode = 2;
    pulse_start();
    wait_idle();
    chk("all_ones", 0, 32'(ones0), 32'd16);

    // Abort mid-sweep, then a clean sweep
    mode = 0;
    pulse_start();
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero();
    pulse_start();
    wait_idle();

    // Start held high: back-to-back sweeps
    @(negedge clk);
    #2 start = 1'b1;
    repeat (80) @(negedge clk);
    #2 start = 1'b0;
    wait_idle();

    // Random truth tables
    mode = 3;
    for (int r = 0; r < 4; r++) begin
      rand_tt = 16'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_start();
      wait_idle();
    end

    // Known function with minterm 7 forced low
    mode = 4;
    pulse_start();
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
